// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch with start/stop and lap/clear buttons, a CE-gated prescaler
// and a single time-multiplexed 7-segment decoder feeding two registered digit outputs.
module stopwatch_ctrl #(
    parameter int PRESCALE_BITS = 15
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       CE,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    output logic [7:0] segments1,
    output logic [7:0] segments2,
    output logic [7:0] LED_OUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = 8'h3F;
            4'd1:    pattern = 8'h06;
            4'd2:    pattern = 8'h5B;
            4'd3:    pattern = 8'h4F;
            4'd4:    pattern = 8'h66;
            4'd5:    pattern = 8'h6D;
            4'd6:    pattern = 8'h7D;
            4'd7:    pattern = 8'h07;
            4'd8:    pattern = 8'h7F;
            4'd9:    pattern = 8'h6F;
            default: pattern = 8'h00;
        endcase
        return pattern;
    endfunction

    state_t                   state_r;
    logic [PRESCALE_BITS-1:0] prescale_r;
    logic [3:0]               ones_r;
    logic [3:0]               tens_r;
    logic [3:0]               lap_ones_r;
    logic [3:0]               lap_tens_r;
    logic                     phase_r;
    logic [2:0]               ss_sync_r;
    logic [2:0]               lap_sync_r;

    logic       ss_press_s;
    logic       lap_press_s;
    logic       advance_s;
    logic       tick_s;
    logic [3:0] next_ones_s;
    logic [3:0] next_tens_s;
    logic [3:0] disp_ones_s;
    logic [3:0] disp_tens_s;
    logic [7:0] dec_out_s;

    // Button synchronisers; preset to ones so a button held through reset is not a press.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            ss_sync_r  <= 3'b111;
            lap_sync_r <= 3'b111;
        end else begin
            ss_sync_r  <= {ss_sync_r[1:0], BTN_SS};
            lap_sync_r <= {lap_sync_r[1:0], BTN_LAP};
        end
    end

    // SS wins when both buttons produce an event in the same cycle.
    assign ss_press_s  = ss_sync_r[1] & ~ss_sync_r[2];
    assign lap_press_s = lap_sync_r[1] & ~lap_sync_r[2] & ~ss_press_s;

    // Prescaler gating, tick detection and BCD successor of the live count.
    always_comb begin
        advance_s   = ((state_r == RUN) || (state_r == LAP)) && CE;
        tick_s      = advance_s && (prescale_r == {PRESCALE_BITS{1'b1}});
        next_ones_s = 4'd0;
        next_tens_s = tens_r;
        if (ones_r == 4'd9) begin
            next_ones_s = 4'd0;
            if (tens_r == 4'd9) begin
                next_tens_s = 4'd0;
            end else begin
                next_tens_s = tens_r + 4'd1;
            end
        end else begin
            next_ones_s = ones_r + 4'd1;
            next_tens_s = tens_r;
        end
    end

    // Mode FSM with prescaler, live count and lap register.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_r    <= IDLE;
            prescale_r <= '0;
            ones_r     <= 4'd0;
            tens_r     <= 4'd0;
            lap_ones_r <= 4'd0;
            lap_tens_r <= 4'd0;
        end else begin
            if (advance_s) begin
                prescale_r <= prescale_r + PRESCALE_BITS'(1);
            end
            if (tick_s) begin
                ones_r <= next_ones_s;
                tens_r <= next_tens_s;
            end
            case (state_r)
                IDLE: begin
                    prescale_r <= '0;
                    ones_r     <= 4'd0;
                    tens_r     <= 4'd0;
                    if (ss_press_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (ss_press_s) begin
                        state_r <= STOP;
                    end else if (lap_press_s) begin
                        state_r    <= LAP;
                        lap_ones_r <= ones_r;
                        lap_tens_r <= tens_r;
                    end
                end
                LAP: begin
                    if (ss_press_s) begin
                        state_r <= STOP;
                    end else if (lap_press_s) begin
                        state_r <= RUN;
                    end
                end
                STOP: begin
                    if (ss_press_s) begin
                        state_r <= RUN;
                    end else if (lap_press_s) begin
                        state_r    <= IDLE;
                        prescale_r <= '0;
                        ones_r     <= 4'd0;
                        tens_r     <= 4'd0;
                        lap_ones_r <= 4'd0;
                        lap_tens_r <= 4'd0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // The frozen lap value is shown only while in LAP; the LEDs always show the live count.
    always_comb begin
        disp_ones_s = (state_r == LAP) ? lap_ones_r : ones_r;
        disp_tens_s = (state_r == LAP) ? lap_tens_r : tens_r;
        dec_out_s   = seg_decode(phase_r ? disp_tens_s : disp_ones_s);
    end

    // Shared decoder output is steered to one digit per phase; the other digit holds.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            phase_r   <= 1'b0;
            segments1 <= 8'h3F;
            segments2 <= 8'h3F;
        end else begin
            phase_r <= ~phase_r;
            if (phase_r) begin
                segments2 <= dec_out_s;
            end else begin
                segments1 <= dec_out_s;
            end
        end
    end

    assign LED_OUT = {tens_r, ones_r};

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_BITS, default 15, prescaler width; one count tick per 2^PRESCALE_BITS enabled cycles.
REQ-002 SHALL have port C  input  1  sole clock; all registers update on the rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port CE  input  1  count enable; gates the prescaler.
REQ-005 SHALL have port BTN_SS  input  1  start/stop button, asynchronous, level.
REQ-006 SHALL have port BTN_LAP  input  1  lap/clear button, asynchronous, level.
REQ-007 SHALL have port segments1  output  8  ones digit, Dgfedcba, 1 = segment on.
REQ-008 SHALL have port segments2  output  8  tens digit, Dgfedcba, 1 = segment on.
REQ-009 SHALL have port LED_OUT  output  8  live BCD count {tens[3:0], ones[3:0]}.

Function
REQ-010 SHALL pass each button through a 3-flop chain s1->s2->s3; press event = s2 & ~s3, one cycle wide.
REQ-011 SHALL apply a press state change on the 3rd rising edge of C after the button rises, with setup met before the 1st edge.
REQ-012 SHALL implement FSM states IDLE, RUN, LAP, STOP.
REQ-013 IDLE: prescaler and count held at 0; SS press -> RUN.
REQ-014 RUN: count advances; display live; SS press -> STOP; LAP press -> LAP, latching the current count into the lap register on the same edge.
REQ-015 LAP: count keeps advancing; display shows the lap register; LAP press -> RUN (display live); SS press -> STOP (display live).
REQ-016 STOP: prescaler and count frozen; SS press -> RUN, resuming from the frozen prescaler value; LAP press -> IDLE, clearing count, prescaler and lap register on that edge.
REQ-017 Simultaneous SS and LAP press events in one cycle SHALL be resolved as SS only; the LAP event is discarded.
REQ-018 The prescaler SHALL increment only in RUN or LAP with CE=1; with CE=0 it holds its value and no tick occurs.
REQ-019 A tick occurs on the edge where the prescaler wraps from all-ones to 0; the count increments on that same edge.
REQ-020 The count SHALL be two BCD digits: ones 9 -> 0 with tens +1; count 99 -> 00 on the next tick; digits never take values A-F.
REQ-021 A single shared 7-segment decoder SHALL be time-multiplexed by a phase bit toggling every cycle.
REQ-022 On phase=0, decode the displayed ones digit into segments1; on phase=1, decode the displayed tens digit into segments2; the other output holds.
REQ-023 Both segment outputs SHALL reflect a displayed-value change within 2 cycles.
REQ-024 Decoder patterns (D=0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; any other input = 00 (blank).
REQ-025 LED_OUT SHALL be combinational from the count register, zero latency, and always show the live count (never the lap register).

Reset
REQ-026 CLR=1 SHALL immediately force state IDLE, prescaler 0, count 00, lap register 00 and phase 0.
REQ-027 CLR=1 SHALL immediately force segments1 = segments2 = 8'h3F and LED_OUT = 00.
REQ-028 CLR=1 SHALL set all synchroniser flops to 1, so a button held through reset release produces no press event.
REQ-029 CLR asserted mid-count or in LAP SHALL discard all state; after release the block behaves as from power-up.

Verification (PRESCALE_BITS=2, CE=1 unless stated)
REQ-030 Reset then SS pulse -> RUN; LED_OUT 00->01 four cycles after the first prescaler increment; segments1 = 06 within 2 cycles.
REQ-031 Run 99 ticks -> LED_OUT=99, segments2=6F, segments1=6F; next tick -> LED_OUT=00, both segments 3F.
REQ-032 At count 12, LAP press -> segments show 12 while LED_OUT advances to 15; LAP press -> segments track LED_OUT within 2 cycles.
REQ-033 SS and LAP rise in the same cycle from RUN -> state STOP, lap register unchanged; then LAP press -> IDLE, LED_OUT=00.
REQ-034 CE=0 for 20 cycles in RUN -> LED_OUT and prescaler unchanged; CE=1 -> counting resumes without a skipped or double tick.
REQ-035 BTN_SS held high across CLR release -> state stays IDLE; release and re-press -> RUN.
